// File: rtl/multibuffer_packer_if.sv
// Bundle for multibuffer_packer: narrow producer side, queue write side
// and accumulator status.
interface multibuffer_packer_if #(
  parameter int DW = 64,
  parameter int QW = 128,
  parameter int CW = 2
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          write_en;
  logic [QW-1:0] data_out;
  logic          waitrequest;
  logic [CW-1:0] lane_cnt;
  logic          busy;

  modport master (
    output in_valid, in_data, flush, waitrequest,
    input  in_ready, write_en, data_out, lane_cnt, busy
  );

  modport slave (
    input  in_valid, in_data, flush, waitrequest,
    output in_ready, write_en, data_out, lane_cnt, busy
  );
endinterface

// File: rtl/multibuffer_packer.sv
// Narrow-to-wide write gearbox feeding multibuffer_queue; lane 0 is LSBs.
// Optional MULTIBUFFER_PACKER_STATS_EN adds words_written/pad_lanes.
module multibuffer_packer #(
  parameter int DATA_IN_WIDTH = 64,
  parameter int Q_DATA_WIDTH  = 128,
  parameter logic [DATA_IN_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic clk,
  input  logic rst_n,
  multibuffer_packer_if.slave bus
`ifdef MULTIBUFFER_PACKER_STATS_EN
  ,
  output logic [31:0] words_written,
  output logic [31:0] pad_lanes
`endif
);
  localparam int R  = Q_DATA_WIDTH / DATA_IN_WIDTH;
  localparam int CW = $clog2(R) + 1;
  localparam logic [CW-1:0] FULL = CW'(R);

  logic [R-1:0][DATA_IN_WIDTH-1:0] acc_q, acc_d;
  logic [R-1:0][DATA_IN_WIDTH-1:0] word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pad_n;
  logic [Q_DATA_WIDTH-1:0] dout_q, dout_d;
  logic we_q, we_d;
  logic pend_q, pend_d;
  logic out_free, rdy, accept, xfer, fl;

  assign out_free = !we_q || !bus.waitrequest;
  assign rdy = !pend_q && (cnt_q != FULL || out_free);
  assign accept = bus.in_valid && rdy;
  assign fl = pend_q || bus.flush;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    we_d   = we_q && bus.waitrequest;
    dout_d = dout_q;
    pend_d = pend_q;
    xfer   = 1'b0;
    word   = acc_q;
    pad_n  = '0;
    // A stalled full word leaves first; a new beat then restarts lane 0.
    if (cnt_q == FULL && out_free) begin
      xfer  = 1'b1;
      cnt_d = '0;
    end
    if (accept) begin
      for (int i = 0; i < R; i++)
        if (CW'(i) == cnt_d) acc_d[i] = bus.in_data;
      cnt_d = cnt_d + CW'(1);
    end
    if (!xfer && cnt_d == FULL && out_free) begin
      xfer  = 1'b1;
      word  = acc_d;
      cnt_d = '0;
    end
    // Flush pads after packing this cycle's beat; waits if out is busy.
    if (fl) begin
      if (cnt_d == '0) begin
        pend_d = 1'b0;
      end else if (!xfer && out_free) begin
        xfer  = 1'b1;
        pad_n = FULL - cnt_d;
        for (int i = 0; i < R; i++)
          word[i] = (CW'(i) < cnt_d) ? acc_d[i] : PAD_VALUE;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
    if (xfer) begin
      we_d   = 1'b1;
      dout_d = word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      dout_q <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      dout_q <= dout_d;
      pend_q <= pend_d;
    end
  end

  assign bus.in_ready = rdy;
  assign bus.write_en = we_q;
  assign bus.data_out = dout_q;
  assign bus.lane_cnt = cnt_q;
  assign bus.busy     = (cnt_q != '0) || we_q;

`ifdef MULTIBUFFER_PACKER_STATS_EN
  logic [31:0] ww_q, pl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ww_q <= '0;
      pl_q <= '0;
    end else begin
      ww_q <= ww_q + 32'(we_q && !bus.waitrequest);
      pl_q <= pl_q + 32'(pad_n);
    end
  end

  assign words_written = ww_q;
  assign pad_lanes     = pl_q;
`endif
endmodule

// File: tb/tb_multibuffer_packer.sv
// Directed bench for multibuffer_packer, 64->128 bit (R=2).
// Accepted queue writes are logged at negedge and compared to hand values.
module tb_multibuffer_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] wq[$];

  always #5 clk = ~clk;

  multibuffer_packer_if #(.DW(64), .QW(128), .CW(2)) bus();

`ifdef MULTIBUFFER_PACKER_STATS_EN
  logic [31:0] words_written, pad_lanes;
  multibuffer_packer #(
    .DATA_IN_WIDTH(64), .Q_DATA_WIDTH(128), .PAD_VALUE(64'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .words_written(words_written), .pad_lanes(pad_lanes)
  );
`else
  multibuffer_packer #(
    .DATA_IN_WIDTH(64), .Q_DATA_WIDTH(128), .PAD_VALUE(64'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  always @(negedge clk)
    if (rst_n && bus.write_en && !bus.waitrequest)
      wq.push_back(bus.data_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.waitrequest = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    wq.delete();
  endtask

  task automatic beat(input logic [63:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (bus.write_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_we got %b exp 0", bus.write_en);
    end
    n_chk++;
    if (bus.data_out !== 128'h0) begin
      n_fail++; $display("FAIL rst_dout got %h exp 0", bus.data_out);
    end
    n_chk++;
    if (bus.lane_cnt !== 2'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cnt_busy got %0d/%b exp 0/0", bus.lane_cnt, bus.busy);
    end
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    beat(64'hA);
    n_chk++;
    if (bus.lane_cnt !== 2'd1 || bus.write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lane1 got %0d/%b exp 1/0", bus.lane_cnt, bus.write_en);
    end
    beat(64'hB);
    n_chk++;
    if (bus.write_en !== 1'b1 || bus.data_out !== {64'hB, 64'hA}) begin
      n_fail++;
      $display("FAIL basic_word got %b %h exp 1 %h", bus.write_en,
               bus.data_out, {64'hB, 64'hA});
    end
    n_chk++;
    if (bus.lane_cnt !== 2'd0) begin
      n_fail++; $display("FAIL basic_cnt got %0d exp 0", bus.lane_cnt);
    end
    tick();
    n_chk++;
    if (bus.write_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drop got %b/%b exp 0/0", bus.write_en, bus.busy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    beat(64'h5);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_chk++;
    if (bus.write_en !== 1'b1 || bus.data_out !== {64'h0, 64'h5}) begin
      n_fail++;
      $display("FAIL flush_pad got %b %h exp 1 %h", bus.write_en,
               bus.data_out, {64'h0, 64'h5});
    end
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_chk++;
    if (bus.write_en !== 1'b0 || bus.lane_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_empty got %b/%0d exp 0/0", bus.write_en, bus.lane_cnt);
    end
    bus.flush = 1'b1;
    beat(64'h6);
    bus.flush = 1'b0;
    n_chk++;
    if (bus.write_en !== 1'b1 || bus.data_out !== {64'h0, 64'h6}) begin
      n_fail++;
      $display("FAIL flush_same_cycle got %b %h exp 1 %h", bus.write_en,
               bus.data_out, {64'h0, 64'h6});
    end
    tick();
    n_chk++;
    if (wq.size() != 2) begin
      n_fail++; $display("FAIL flush_count got %0d exp 2", wq.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.waitrequest = 1'b1;
    beat(64'h1);
    beat(64'h2);
    beat(64'h3);
    beat(64'h4);
    bus.in_valid = 1'b1;
    bus.in_data = 64'h5;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (bus.write_en !== 1'b1 || bus.data_out !== {64'h2, 64'h1} ||
          bus.lane_cnt !== 2'd2 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got %b %h %0d %b exp 1 %h 2 0", i,
                 bus.write_en, bus.data_out, bus.lane_cnt, bus.in_ready,
                 {64'h2, 64'h1});
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.waitrequest = 1'b0;
    tick();
    n_chk++;
    if (bus.write_en !== 1'b1 || bus.data_out !== {64'h4, 64'h3}) begin
      n_fail++;
      $display("FAIL stall_second got %b %h exp 1 %h", bus.write_en,
               bus.data_out, {64'h4, 64'h3});
    end
    tick();
    n_chk++;
    if (wq.size() != 2 || bus.write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count got %0d/%b exp 2/0", wq.size(), bus.write_en);
    end else begin
      n_chk++;
      if (wq[0] !== {64'h2, 64'h1} || wq[1] !== {64'h4, 64'h3}) begin
        n_fail++; $display("FAIL stall_order got %h %h", wq[0], wq[1]);
      end
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    bus.waitrequest = 1'b1;
    beat(64'h1);
    beat(64'h2);
    beat(64'h3);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 64'h99;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (bus.in_ready !== 1'b0 || bus.lane_cnt !== 2'd1 ||
          bus.write_en !== 1'b1) begin
        n_fail++;
        $display("FAIL fstall_hold[%0d] got %b %0d %b exp 0 1 1", i,
                 bus.in_ready, bus.lane_cnt, bus.write_en);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.waitrequest = 1'b0;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fstall_pend_ready got %b exp 0", bus.in_ready);
    end
    tick();
    n_chk++;
    if (bus.write_en !== 1'b1 || bus.data_out !== {64'h0, 64'h3} ||
        bus.lane_cnt !== 2'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fstall_word got %b %h %0d %b exp 1 %h 0 1",
               bus.write_en, bus.data_out, bus.lane_cnt, bus.in_ready,
               {64'h0, 64'h3});
    end
    tick();
    n_chk++;
    if (wq.size() != 2) begin
      n_fail++; $display("FAIL fstall_count got %0d exp 2", wq.size());
    end else begin
      n_chk++;
      if (wq[0] !== {64'h2, 64'h1} || wq[1] !== {64'h0, 64'h3}) begin
        n_fail++; $display("FAIL fstall_order got %h %h", wq[0], wq[1]);
      end
    end
`ifdef MULTIBUFFER_PACKER_STATS_EN
    n_chk++;
    if (pad_lanes !== 32'd1 || words_written !== 32'd2) begin
      n_fail++;
      $display("FAIL fstall_stats got %0d/%0d exp 1/2", pad_lanes, words_written);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.waitrequest = 1'b1;
    beat(64'h7);
    beat(64'h8);
    beat(64'h9);
    n_chk++;
    if (bus.write_en !== 1'b1 || bus.lane_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL rmid_pre got %b/%0d exp 1/1", bus.write_en, bus.lane_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.write_en !== 1'b0 || bus.data_out !== 128'h0 ||
        bus.lane_cnt !== 2'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async got %b %h %0d %b exp 0 0 0 0", bus.write_en,
               bus.data_out, bus.lane_cnt, bus.busy);
    end
    bus.waitrequest = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    beat(64'h11);
    beat(64'h12);
    n_chk++;
    if (bus.write_en !== 1'b1 || bus.data_out !== {64'h12, 64'h11}) begin
      n_fail++;
      $display("FAIL rmid_new got %b %h exp 1 %h", bus.write_en,
               bus.data_out, {64'h12, 64'h11});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int cyc = 0;
    int nw = 0;
    do_reset();
    while (idx < 1024 && cyc < 8000) begin
      bus.waitrequest = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      bus.in_data = 64'(idx);
      #1;
      if (bus.in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.waitrequest = 1'b0;
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    n_chk++;
    if (idx != 1024 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain got %0d beats busy=%b exp 1024 0", idx, bus.busy);
    end
    n_chk++;
    if (wq.size() != 512) begin
      n_fail++; $display("FAIL b2b_count got %0d exp 512", wq.size());
    end
    nw = (wq.size() < 512) ? wq.size() : 512;
    for (int k = 0; k < nw; k++) begin
      n_chk++;
      if (wq[k] !== {64'(2 * k + 1), 64'(2 * k)}) begin
        n_fail++;
        $display("FAIL b2b_word[%0d] got %h exp %h", k, wq[k],
                 {64'(2 * k + 1), 64'(2 * k)});
      end
    end
`ifdef MULTIBUFFER_PACKER_STATS_EN
    n_chk++;
    if (words_written !== 32'd512 || pad_lanes !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_stats got %0d/%0d exp 512/0", words_written, pad_lanes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_stall();
    test_flush_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
